// File: rtl/ibex_dummy_instr_burst_pkg.sv
// Shared types and constants for the dummy-instruction burst inserter.
// Enumerations for dummy types and inserter FSM, RV32 R-type encoding fields,
// LFSR polynomial/seed and the dummy instruction encoder.
package ibex_dummy_instr_burst_pkg;

    // Dummy instruction type; the value doubles as the bit index into the type-enable mask.
    typedef enum logic [1:0] {
        DUMMY_ADD = 2'd0,
        DUMMY_MUL = 2'd1,
        DUMMY_DIV = 2'd2,
        DUMMY_AND = 2'd3
    } dummy_instr_e;

    typedef enum logic {
        DUMMY_COUNT = 1'b0,
        DUMMY_BURST = 1'b1
    } dummy_state_e;

    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] FUNCT7_ALU    = 7'h00;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;
    localparam logic [2:0] FUNCT3_ADD    = 3'b000;
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_AND    = 3'b111;

    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2468;

    // Build an R-type word writing x0, so the result is architecturally invisible.
    function automatic logic [31:0] dummy_encode(dummy_instr_e t, logic [4:0] op_a,
                                                 logic [4:0] op_b);
        logic [6:0] funct7;
        logic [2:0] funct3;
        funct7 = FUNCT7_ALU;
        funct3 = FUNCT3_ADD;
        case (t)
            DUMMY_ADD: begin
                funct7 = FUNCT7_ALU;
                funct3 = FUNCT3_ADD;
            end
            DUMMY_MUL: begin
                funct7 = FUNCT7_MULDIV;
                funct3 = FUNCT3_MUL;
            end
            DUMMY_DIV: begin
                funct7 = FUNCT7_MULDIV;
                funct3 = FUNCT3_DIV;
            end
            DUMMY_AND: begin
                funct7 = FUNCT7_ALU;
                funct3 = FUNCT3_AND;
            end
            default: begin
                funct7 = FUNCT7_ALU;
                funct3 = FUNCT3_ADD;
            end
        endcase
        return {funct7, op_b, op_a, funct3, 5'h00, OPCODE_OP};
    endfunction

endpackage

// File: rtl/ibex_dummy_lfsr.sv
// 32-bit Galois LFSR feeding the dummy-instruction inserter.
// Reseed XORs the seed into the state and has priority over stepping; any
// all-zero result is replaced by SEED so the register can never lock up.
module ibex_dummy_lfsr
    import ibex_dummy_instr_burst_pkg::*;
#(
    parameter logic [31:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        seed_en_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;
    logic [31:0] stepped;
    logic [31:0] reseeded;

    // Next state: reseed, else step, else hold; zero results fall back to SEED.
    always_comb begin
        stepped  = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_POLY : 32'h0);
        reseeded = state_q ^ seed_i;
        state_d  = state_q;
        if (seed_en_i) begin
            state_d = (reseeded == 32'h0) ? SEED : reseeded;
        end else if (step_i) begin
            state_d = (stepped == 32'h0) ? SEED : stepped;
        end
    end

    // State register with synchronous reset to SEED.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ibex_dummy_instr_burst.sv
// Dummy-instruction inserter with burst support for the IF stage.
// Counts real instructions handed to ID and, once the count reaches an
// LFSR-derived threshold, inserts a burst of pseudo-random R-type ALU/MD
// instructions writing x0. At least one real instruction separates events.
// Optional build macro: IBEX_DUMMY_INSTR_STATS_EN adds a saturating count of
// accepted dummies on dummy_instr_count_o (tied to zero otherwise).
module ibex_dummy_instr_burst
    import ibex_dummy_instr_burst_pkg::*;
#(
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned BURST_W   = 2,
    parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               dummy_instr_en_i,
    input  logic [CNT_W-1:0]   dummy_instr_mask_i,
    input  logic [3:0]         dummy_type_en_i,
    input  logic [BURST_W-1:0] dummy_burst_len_i,
    input  logic               dummy_instr_seed_en_i,
    input  logic [31:0]        dummy_instr_seed_i,
    input  logic               fetch_valid_i,
    input  logic               id_in_ready_i,
    output logic               insert_dummy_instr_o,
    output logic [31:0]        dummy_instr_data_o,
    output logic               dummy_busy_o,
    output logic [31:0]        dummy_instr_count_o
);

    dummy_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] rem_q, rem_d;

    logic [31:0]        lfsr_state;
    logic [CNT_W-1:0]   cnt_f;
    logic [CNT_W-1:0]   thr_raw;
    logic [CNT_W-1:0]   thr;
    logic [4:0]         op_a;
    logic [4:0]         op_b;
    dummy_instr_e       sel_type;
    dummy_instr_e       dummy_type;
    logic [BURST_W-1:0] burst_eff;
    logic               insert;
    logic               accept;
    logic               unused_lfsr_hi;

    ibex_dummy_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .seed_en_i (dummy_instr_seed_en_i),
        .seed_i    (dummy_instr_seed_i),
        .step_i    (accept),
        .state_o   (lfsr_state)
    );

    // Carve threshold, operands and type out of consecutive LFSR bit fields.
    always_comb begin
        cnt_f      = lfsr_state[CNT_W-1:0];
        op_a       = lfsr_state[CNT_W +: 5];
        op_b       = lfsr_state[CNT_W + 5 +: 5];
        sel_type   = dummy_instr_e'(lfsr_state[CNT_W + 10 +: 2]);
        dummy_type = dummy_type_en_i[sel_type] ? sel_type : DUMMY_ADD;
        thr_raw    = cnt_f & dummy_instr_mask_i;
        // A zero threshold would insert back-to-back; force at least one real instruction.
        thr        = (thr_raw == '0) ? CNT_W'(1) : thr_raw;
        burst_eff  = (dummy_burst_len_i == '0) ? BURST_W'(1) : dummy_burst_len_i;
    end

    assign unused_lfsr_hi = ^(lfsr_state >> (CNT_W + 12));

    // FSM next state, counters and combinational insert decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        insert  = 1'b0;
        if (!dummy_instr_en_i) begin
            state_d = DUMMY_COUNT;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                DUMMY_COUNT: begin
                    insert = (cnt_q == thr);
                    if (insert) begin
                        if (id_in_ready_i) begin
                            cnt_d = '0;
                            rem_d = burst_eff - BURST_W'(1);
                            if (burst_eff > BURST_W'(1)) begin
                                state_d = DUMMY_BURST;
                            end
                        end
                    end else if (fetch_valid_i && id_in_ready_i) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DUMMY_BURST: begin
                    insert = 1'b1;
                    if (id_in_ready_i) begin
                        rem_d = rem_q - BURST_W'(1);
                        if (rem_q == BURST_W'(1)) begin
                            state_d = DUMMY_COUNT;
                        end
                    end
                end
                default: begin
                    state_d = DUMMY_COUNT;
                    cnt_d   = '0;
                    rem_d   = '0;
                end
            endcase
        end
    end

    assign accept = insert & id_in_ready_i;

    // FSM and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DUMMY_COUNT;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

    // Outputs are forced low while reset is held, even before state is initialised.
    always_comb begin
        insert_dummy_instr_o = insert & ~rst_i;
        dummy_busy_o         = (state_q == DUMMY_BURST) & ~rst_i;
        dummy_instr_data_o   = rst_i ? 32'h0 : dummy_encode(dummy_type, op_a, op_b);
    end

`ifdef IBEX_DUMMY_INSTR_STATS_EN
    logic [31:0] count_q;

    // Saturating count of dummies accepted by ID.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 32'h0;
        end else if (accept && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign dummy_instr_count_o = rst_i ? 32'h0 : count_q;
`else
    assign dummy_instr_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_ibex_dummy_instr_burst.sv
// Directed self-checking bench for ibex_dummy_instr_burst (default parameters).
module tb_ibex_dummy_instr_burst;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [4:0]  mask;
    logic [3:0]  type_en;
    logic [1:0]  burst;
    logic        seed_en;
    logic [31:0] seed;
    logic        fv;
    logic        rdy;
    logic        ins;
    logic [31:0] data;
    logic        busy;
    logic [31:0] count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_lfsr;
    int          m_acc;
    logic [31:0] last_data;
    logic [3:0]  seen;
    int          thr;
    logic [31:0] tmp;

    ibex_dummy_instr_burst dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .dummy_instr_en_i      (en),
        .dummy_instr_mask_i    (mask),
        .dummy_type_en_i       (type_en),
        .dummy_burst_len_i     (burst),
        .dummy_instr_seed_en_i (seed_en),
        .dummy_instr_seed_i    (seed),
        .fetch_valid_i         (fv),
        .id_in_ready_i         (rdy),
        .insert_dummy_instr_o  (ins),
        .dummy_instr_data_o    (data),
        .dummy_busy_o          (busy),
        .dummy_instr_count_o   (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Galois step for x^32 + x^22 + x^2 + x + 1 (taps at bits 31, 21, 1, 0).
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Expected dummy word for CNT_W=5: op_a=[9:5], op_b=[14:10], type=[16:15].
    function automatic logic [31:0] exp_word(input logic [31:0] s, input logic [3:0] ten);
        logic [1:0] t;
        logic [6:0] f7;
        logic [2:0] f3;
        t = s[16:15];
        if (!ten[t]) t = 2'd0;
        case (t)
            2'd0:    begin f7 = 7'd0; f3 = 3'b000; end
            2'd1:    begin f7 = 7'd1; f3 = 3'b000; end
            2'd2:    begin f7 = 7'd1; f3 = 3'b100; end
            default: begin f7 = 7'd0; f3 = 3'b111; end
        endcase
        return {f7, s[14:10], s[9:5], f3, 5'd0, 7'h33};
    endfunction

    function automatic logic [1:0] classify(input logic [31:0] w);
        if (w[31:25] == 7'd1) return (w[14:12] == 3'b100) ? 2'd2 : 2'd1;
        return (w[14:12] == 3'b111) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef IBEX_DUMMY_INSTR_STATS_EN
        return 32'(m_acc);
`else
        return 32'h0;
`endif
    endfunction

    // One clock: check outputs against expectations, advance the model past the edge.
    task automatic cyc(input logic ei, input logic eb, input string tag);
        #1;
        check_eq({tag, ".ins"}, {31'b0, ins}, {31'b0, ei});
        check_eq({tag, ".busy"}, {31'b0, busy}, {31'b0, eb});
        check_eq({tag, ".lfsr"}, dut.u_lfsr.state_q, m_lfsr);
        check_eq({tag, ".count"}, count, exp_count());
        if (ei) begin
            last_data = data;
            check_eq({tag, ".data"}, data, exp_word(m_lfsr, type_en));
            check_eq({tag, ".rd_op"}, {20'b0, data[11:0]}, 32'h0000_0033);
        end
        @(posedge clk);
        if (ei && rdy) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_acc++;
        end
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, ".ins"}, {31'b0, ins}, 32'h0);
        check_eq({tag, ".data"}, data, 32'h0);
        check_eq({tag, ".busy"}, {31'b0, busy}, 32'h0);
        check_eq({tag, ".count"}, count, 32'h0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mask = 5'h0; type_en = 4'hF; burst = 2'd0;
        seed_en = 1'b0; seed = 32'h0; fv = 1'b1; rdy = 1'b1;
        m_acc = 0; last_data = 32'h0; seen = 4'h0;
        #2;
        check_reset_outs("rst_hold");
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        m_lfsr = SEED;
        check_eq("rst_lfsr", dut.u_lfsr.state_q, SEED);
        check_eq("rst_cnt", 32'(dut.cnt_q), 32'h0);

        // Disabled: no insertion, LFSR frozen at the seed.
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, "dis");

        // mask=0, burst=0: strict real/dummy alternation.
        en = 1'b1;
        for (int i = 0; i < 20; i++) cyc(i % 2 == 1, 1'b0, "alt");

        // burst=3: real, then three dummies (last two in BURST).
        burst = 2'd3;
        for (int i = 0; i < 10; i++) cyc((i % 4) != 0, (i % 4) >= 2, "burst");
        // Now in BURST with two dummies left; stall ID for five cycles.
        rdy = 1'b0;
        tmp = data;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, "bstall");
            check_eq("bstall.stable", data, tmp);
        end
        rdy = 1'b1;
        cyc(1'b1, 1'b1, "bres");
        cyc(1'b1, 1'b1, "bres");
        cyc(1'b0, 1'b0, "bres");
        cyc(1'b1, 1'b0, "bres");

        // Reset in BURST with two dummies remaining.
        check_eq("pre_rst.busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        m_lfsr = SEED; m_acc = 0;
        check_eq("post_rst.cnt", 32'(dut.cnt_q), 32'h0);
        cyc(1'b0, 1'b0, "post_rst");

        // Enable drop while a dummy is due: insert falls at once, counter clears.
        burst = 2'd0;
        check_eq("en_due.ins", {31'b0, ins}, 32'h1);
        en = 1'b0;
        cyc(1'b0, 1'b0, "en_off");
        en = 1'b1;
        check_eq("en_off.cnt", 32'(dut.cnt_q), 32'h0);

        // Stall in COUNT while a dummy is offered.
        cyc(1'b0, 1'b0, "cnt");
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, "cstall");
        rdy = 1'b1;
        cyc(1'b1, 1'b0, "cstall_go");

        // Only ADD enabled: 64 dummies, all ADD.
        type_en = 4'b0001;
        for (int i = 0; i < 128; i++) begin
            cyc(i % 2 == 1, 1'b0, "tadd");
            if (i % 2 == 1) check_eq("tadd.funct", {last_data[31:25], last_data[14:12]}, 32'h0);
        end

        // All types enabled: every encoding should appear.
        type_en = 4'b1111;
        for (int i = 0; i < 128; i++) begin
            cyc(i % 2 == 1, 1'b0, "tall");
            if (i % 2 == 1) seen[classify(last_data)] = 1'b1;
        end
        check_eq("tall.seen", {28'b0, seen}, 32'hF);

        // Threshold from LFSR under a full and a partial mask.
        mask = 5'h1F;
        thr = int'(m_lfsr[4:0] & mask);
        if (thr == 0) thr = 1;
        for (int i = 0; i < thr; i++) cyc(1'b0, 1'b0, "thr_full");
        cyc(1'b1, 1'b0, "thr_full");
        mask = 5'h03;
        thr = int'(m_lfsr[4:0] & mask);
        if (thr == 0) thr = 1;
        for (int i = 0; i < thr; i++) cyc(1'b0, 1'b0, "thr_part");
        cyc(1'b1, 1'b0, "thr_part");

        // Reseed: seed equal to state -> fallback seed; zero seed -> unchanged.
        en = 1'b0; mask = 5'h0;
        cyc(1'b0, 1'b0, "pre_seed");
        seed_en = 1'b1; seed = m_lfsr;
        @(posedge clk); #1;
        m_lfsr = SEED;
        check_eq("seed_eq", dut.u_lfsr.state_q, m_lfsr);
        seed = 32'h0;
        @(posedge clk); #1;
        check_eq("seed_zero", dut.u_lfsr.state_q, m_lfsr);
        seed = 32'h1234_5678;
        @(posedge clk); #1;
        m_lfsr = m_lfsr ^ 32'h1234_5678;
        check_eq("seed_xor", dut.u_lfsr.state_q, m_lfsr);
        seed_en = 1'b0;

        // Reseed coinciding with an accepted dummy wins over the LFSR step.
        en = 1'b1;
        cyc(1'b0, 1'b0, "seed_acc");
        seed_en = 1'b1; seed = 32'h0F0F_0F0F;
        #1;
        check_eq("seed_acc.ins", {31'b0, ins}, 32'h1);
        check_eq("seed_acc.data", data, exp_word(m_lfsr, type_en));
        @(posedge clk); #1;
        seed_en = 1'b0;
        m_lfsr = m_lfsr ^ 32'h0F0F_0F0F;
        if (m_lfsr == 32'h0) m_lfsr = SEED;
        m_acc++;
        check_eq("seed_acc.lfsr", dut.u_lfsr.state_q, m_lfsr);
        cyc(1'b0, 1'b0, "seed_after");
        cyc(1'b1, 1'b0, "seed_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
